ram_dma: RTL
============

RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  request a transfer; sampled only in IDLE.
REQ-006 The block SHALL have port src_addr  input  ADDR_W  first source byte address (copy mode).
REQ-007 The block SHALL have port dst_addr  input  ADDR_W  first destination byte address.
REQ-008 The block SHALL have port len  input  ADDR_W  number of bytes to transfer.
REQ-009 The block SHALL have port fill_mode  input  1  1 = write fill_data to the destination range instead of copying.
REQ-010 The block SHALL have port fill_data  input  DATA_W  fill byte.
REQ-011 The block SHALL have port busy  output  1  transfer in progress, including the DONE cycle.
REQ-012 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port ram_cs  output  1  drives RAM chipsel.
REQ-014 The block SHALL have port ram_we  output  1  drives RAM writeEn.
REQ-015 The block SHALL have port ram_re  output  1  drives RAM readEn.
REQ-016 The block SHALL have port ram_addr  output  ADDR_W  drives RAM addrIn.
REQ-017 The block SHALL have port ram_wdata  output  DATA_W  drives RAM busIn.
REQ-018 The block SHALL have port ram_rdata  input  DATA_W  from RAM busOut; valid in the cycle after the edge that sampled ram_re=1.

Function
REQ-019 The FSM SHALL have states IDLE, RD_ISSUE, RD_WAIT, WR and DONE.
REQ-020 In IDLE, start=1 SHALL latch src_addr, dst_addr, len, fill_mode and fill_data, clear the byte index i, and set busy=1 from the next cycle; the latched values SHALL NOT change until the transfer finishes.
REQ-021 If len=0 at start, the FSM SHALL go IDLE->DONE with no RAM access.
REQ-022 In copy mode, the first state after start SHALL be RD_ISSUE; in fill mode it SHALL be WR.
REQ-023 In RD_ISSUE, the block SHALL drive ram_cs=1, ram_re=1, ram_we=0 and ram_addr=src+i, then go to RD_WAIT.
REQ-024 In RD_WAIT, the block SHALL drive ram_cs=1 with ram_re=0 and ram_we=0, capture ram_rdata into the data register at the end of the cycle, then go to WR.
REQ-025 In WR, the block SHALL drive ram_cs=1, ram_we=1, ram_re=0, ram_addr=dst+i, and ram_wdata = the captured byte (copy) or fill_data (fill).
REQ-026 At the end of WR, i SHALL increment; if i+1=len the FSM SHALL go to DONE, otherwise to RD_ISSUE (copy) or WR (fill).
REQ-027 Copy throughput SHALL be 3 cycles/byte; fill throughput SHALL be 1 cycle/byte.
REQ-028 In DONE, done=1 and busy=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 Address arithmetic SHALL be modulo 2^ADDR_W: src+i and dst+i wrap 16'hFFFF->16'h0000 with no error.
REQ-030 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-031 In IDLE and DONE, ram_cs, ram_we and ram_re SHALL be 0; ram_we and ram_re SHALL never be 1 in the same cycle.
REQ-032 Overlapping source and destination ranges SHALL be copied in ascending address order with no overlap correction.

Reset
REQ-033 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE and busy, done, ram_cs, ram_we, ram_re, ram_addr, ram_wdata, i and the data register SHALL all be 0.
REQ-034 Reset mid-transfer SHALL abort the transfer immediately with no done pulse; bytes already written SHALL remain in the RAM.
REQ-035 start SHALL be ignored in any cycle where rst_n=0.

Configuration
REQ-036 With macro RAM_DMA_FILL_EN defined, fill mode SHALL behave per REQ-022 and REQ-025 to REQ-027.
REQ-037 Without RAM_DMA_FILL_EN, fill_mode and fill_data SHALL be ignored, every transfer SHALL be a copy, and no fill logic SHALL be synthesized; the ports SHALL remain present.

Verification
REQ-038 Copy: RAM[0x0000..0x0003]=BE,EF,12,34; start with src=0x0000, dst=0x0FAA, len=4 -> RAM[0x0FAA..0x0FAD]=BE,EF,12,34; done pulses 13 cycles after the start edge.
REQ-039 Fill (RAM_DMA_FILL_EN defined): dst=0x0100, len=3, fill_data=0xEA -> RAM[0x100..0x102]=EA; done pulses 4 cycles after the start edge; ram_re is never 1.
REQ-040 Wrap: copy with src=0xFFFF, dst=0xFFFE, len=3 -> reads from FFFF,0000,0001 and writes to FFFE,FFFF,0000 in that order.
REQ-041 len=0 -> no ram_cs activity; done=1 in the cycle after the start edge.
REQ-042 Reset and overlap: rst_n=0 during the 2nd byte of a len=8 copy -> all outputs 0 next cycle and no done pulse; start held high during a transfer -> exactly one transfer occurs.

Source files
------------

// File: rtl/ram_dma.sv
// ram_dma: byte-serial RAM-to-RAM copy engine driving a single-port RAM.
// Optional feature: define RAM_DMA_FILL_EN to enable fill mode
// (fill_mode/fill_data). Without it every transfer is a copy.
//
// state    | meaning
// IDLE     | waiting for start, RAM strobes low
// RD_ISSUE | read strobe to src+i
// RD_WAIT  | RAM returns the byte, captured into the data register
// WR       | write byte to dst+i, advance i
// DONE     | one-cycle completion pulse, busy still high
module ram_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR       = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic [DATA_W-1:0] data_q;
  logic              fill_sel;
  logic              fill_q;
  logic [DATA_W-1:0] fdata_q;

  assign idx_nxt = idx + ONE;

`ifdef RAM_DMA_FILL_EN
  assign fill_sel = fill_mode;

  // Fill configuration is frozen at start for the whole transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q  <= 1'b0;
      fdata_q <= '0;
    end else if (state == IDLE && start) begin
      fill_q  <= fill_mode;
      fdata_q <= fill_data;
    end
  end
`else
  // Ports stay for pin compatibility; values are deliberately dropped
  logic unused_fill;
  assign unused_fill = ^{fill_mode, fill_data};
  assign fill_sel    = 1'b0;
  assign fill_q      = 1'b0;
  assign fdata_q     = '0;
`endif

  // Sequencer: latch the request, then step read/wait/write per byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            idx   <= '0;
            if (len == '0)
              state <= DONE;
            else if (fill_sel)
              state <= WR;
            else
              state <= RD_ISSUE;
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          data_q <= ram_rdata;
          state  <= WR;
        end
        WR: begin
          idx <= idx_nxt;
          if (idx_nxt == len_q)
            state <= DONE;
          else if (fill_q)
            state <= WR;
          else
            state <= RD_ISSUE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM strobes and status decode straight from state; address wraps mod 2^ADDR_W
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      RD_ISSUE: begin
        ram_cs   = 1'b1;
        ram_re   = 1'b1;
        ram_addr = src_q + idx;
      end
      RD_WAIT: begin
        ram_cs   = 1'b1;
        ram_addr = src_q + idx;
      end
      WR: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = dst_q + idx;
        ram_wdata = fill_q ? fdata_q : data_q;
      end
      default: begin
        ram_cs = 1'b0;
      end
    endcase
  end

endmodule
